// File: rtl/pseudo_pad_serializer.sv
// Buffers pseudo-random words in a small FIFO and plays them out LSB-first as LANE-bit strobed
// beats on the user pads. Define PSEUDO_SER_FRAME_EN to prefix every word with an A5 sync beat.
module pseudo_pad_serializer #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8,
  parameter int DEPTH = 4,
  parameter int DIV   = 4
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_ni,
  input  logic                       en_i,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       pad_hold_i,
  output logic [LANE-1:0]            pad_data_o,
  output logic                       pad_strb_o,
  output logic [LANE:0]              pad_oeb_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic                       busy_o
);

  localparam int BEATS = WIDTH / LANE;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(2 * DIV) + 1;
  localparam int BC_W  = $clog2(BEATS) + 1;

  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(DIV - 1);
  localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BEATS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);
`ifdef PSEUDO_SER_FRAME_EN
  localparam logic [CNT_W-1:0] FULL_END  = CNT_W'(2 * DIV - 1);
  localparam logic [LANE-1:0]  SYNC      = LANE'(8'hA5);
`endif

  typedef enum logic [1:0] {IDLE, FRAME, SETUP, STROBE} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [BC_W-1:0]     bc_reg, bc_next;
  logic [WIDTH-1:0]    sr_reg, sr_next;
  logic [LANE-1:0]     data_reg, data_next;
  logic                strb_reg, strb_next;
  logic [LANE:0]       oeb_reg;
  logic                ready_reg;
  logic [LVL_W-1:0]    level_reg, level_next;
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [WIDTH-1:0]    mem [DEPTH];
  logic [WIDTH-1:0]    head;
  logic [WIDTH-1:0]    shifted;
  logic                push, pop, load;

  assign push    = in_valid_i & ready_reg;
  assign head    = mem[rd_ptr_reg];
  assign shifted = sr_reg >> LANE;

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data_i;
    end
  end

  always_comb begin
    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_W'(1);
    end else if (!push && pop) begin
      level_next = level_reg - LVL_W'(1);
    end
  end

  // Next-state and next-output logic; pad_hold_i freezes everything except the FIFO push side.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bc_next    = bc_reg;
    sr_next    = sr_reg;
    data_next  = data_reg;
    strb_next  = strb_reg;
    pop        = 1'b0;
    load       = 1'b0;
    if (!pad_hold_i) begin
      case (state_reg)
        IDLE: begin
          strb_next = 1'b0;
          load      = en_i && (level_reg != '0);
        end
`ifdef PSEUDO_SER_FRAME_EN
        FRAME: begin
          if (cnt_reg == FULL_END) begin
            cnt_next   = '0;
            strb_next  = 1'b0;
            data_next  = sr_reg[LANE-1:0];
            bc_next    = '0;
            state_next = SETUP;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == HALF_END) begin
              strb_next = 1'b1;
            end
          end
        end
`endif
        SETUP: begin
          if (cnt_reg == HALF_END) begin
            cnt_next   = '0;
            strb_next  = 1'b1;
            state_next = STROBE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_reg == HALF_END) begin
            cnt_next  = '0;
            strb_next = 1'b0;
            if (bc_reg == LAST_BEAT) begin
              load = en_i && (level_reg != '0);
              if (!load) begin
                state_next = IDLE;
              end
            end else begin
              sr_next    = shifted;
              data_next  = shifted[LANE-1:0];
              bc_next    = bc_reg + BC_W'(1);
              state_next = SETUP;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        default: state_next = IDLE;
      endcase
      // Word start: pop the head and show its first beat (or the sync beat) next cycle.
      if (load) begin
        pop       = 1'b1;
        sr_next   = head;
        cnt_next  = '0;
        bc_next   = '0;
        strb_next = 1'b0;
`ifdef PSEUDO_SER_FRAME_EN
        state_next = FRAME;
        data_next  = SYNC;
`else
        state_next = SETUP;
        data_next  = head[LANE-1:0];
`endif
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bc_reg     <= '0;
      sr_reg     <= '0;
      data_reg   <= '0;
      strb_reg   <= 1'b0;
      oeb_reg    <= '1;
      ready_reg  <= 1'b0;
      level_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bc_reg    <= bc_next;
      sr_reg    <= sr_next;
      data_reg  <= data_next;
      strb_reg  <= strb_next;
      oeb_reg   <= {(LANE + 1){~en_i}};
      // Ready looks at next occupancy so a full FIFO stays closed during the popping cycle.
      ready_reg <= (level_next != FULL_LVL);
      level_reg <= level_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

  assign in_ready_o   = ready_reg;
  assign pad_data_o   = data_reg;
  assign pad_strb_o   = strb_reg;
  assign pad_oeb_o    = oeb_reg;
  assign fifo_level_o = level_reg;
  assign busy_o       = (state_reg != IDLE);

endmodule

// File: tb/tb_pseudo_pad_serializer.sv
// Bench for pseudo_pad_serializer: a time-indexed word playback model checked every cycle,
// plus directed scenarios with literal beat/timing expectations.
`timescale 1ns/1ps
module tb_pseudo_pad_serializer;
  localparam int WIDTH = 32;
  localparam int LANE  = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;
  localparam int BEATS = WIDTH / LANE;
`ifdef PSEUDO_SER_FRAME_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif
  localparam int T = 2 * DIV * NB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  logic             hold = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic [LANE-1:0]  pad_data;
  logic             pad_strb;
  logic [LANE:0]    pad_oeb;
  logic [2:0]       level;
  logic             busy;

  pseudo_pad_serializer #(.WIDTH(WIDTH), .LANE(LANE), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .en_i(en), .in_data_i(in_data), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .pad_hold_i(hold), .pad_data_o(pad_data), .pad_strb_o(pad_strb),
    .pad_oeb_o(pad_oeb), .fifo_level_o(level), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a word popped at an edge shows beat (t-1)/(2*DIV) for t = 1..T cycles after it.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_word = '0;
  bit               m_active = 1'b0;
  int               m_t = 0;
  logic             m_ready = 1'b0;
  logic [LANE:0]    m_oeb = '1;
  logic [LANE-1:0]  m_data = '0;
  logic             m_strb = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_word = '0; m_active = 1'b0; m_t = 0;
      m_ready = 1'b0; m_oeb = '1; m_data = '0; m_strb = 1'b0;
    end
    chk("ready", in_ready, m_ready);
    chk("data", pad_data, m_data);
    chk("strb", pad_strb, m_strb);
    chk("oeb", pad_oeb, m_oeb);
    chk("level", level, mq.size());
    chk("busy", busy, m_active);
    if (rst_n) begin
      bit push;
      int ph, b;
      push = in_valid && m_ready;
      if (!hold) begin
        if (!m_active || m_t == T) begin
          if (en && mq.size() > 0) begin
            m_word = mq.pop_front(); m_active = 1'b1; m_t = 1;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_t++;
        end
      end
      if (push) mq.push_back(in_data);
      m_ready = (mq.size() != DEPTH);
      m_oeb = en ? '0 : '1;
      if (m_active) begin
        ph = (m_t - 1) % (2 * DIV);
        b  = (m_t - 1) / (2 * DIV);
        m_strb = (ph >= DIV);
`ifdef PSEUDO_SER_FRAME_EN
        if (b == 0) m_data = LANE'(8'hA5);
        else        m_data = LANE'(m_word >> (LANE * (b - 1)));
`else
        m_data = LANE'(m_word >> (LANE * b));
`endif
      end else begin
        m_strb = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    tick(); in_valid = 1'b1; in_data = w;
    tick(); in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int c = 0;
    do begin @(negedge clk); c++; end while (busy && c < limit);
    chk("idle_timeout", busy, 0);
  endtask

  // Plays one word (en already raised) and checks the beats seen at each strobe rise.
  task automatic run_word(input string nm, input int exp_n,
                          input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3, input logic [7:0] e4,
                          input int exp_busy, input int hold_at, input int drop_at);
    logic [7:0] seen [8];
    logic [7:0] exp_b [5];
    int n = 0, busy_cnt = 0, strb_cnt = 0, hold_left = 0, cyc = 0;
    bit drop_pending = 1'b0, done = 1'b0;
    logic prev = 1'b0;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = e2; exp_b[3] = e3; exp_b[4] = e4;
    for (int i = 0; i < 8; i++) seen[i] = '0;
    while (!done && cyc < 400) begin
      tick();
      hold = (hold_left > 0);
      if (hold_left > 0) hold_left--;
      if (drop_pending) begin en = 1'b0; drop_pending = 1'b0; end
      @(negedge clk);
      cyc++;
      if (pad_strb && !prev) begin
        if (n < 8) seen[n] = pad_data;
        n++;
        if (n == hold_at) hold_left = 10;
        if (n == drop_at) drop_pending = 1'b1;
      end
      prev = pad_strb;
      if (busy) busy_cnt++;
      if (pad_strb) strb_cnt++;
      if (busy_cnt > 0 && !busy) done = 1'b1;
    end
    hold = 1'b0;
    chk({nm, "_timeout"}, done, 1);
    chk({nm, "_nbeats"}, n, exp_n);
    for (int i = 0; i < exp_n && i < 5; i++) chk({nm, "_beat"}, seen[i], exp_b[i]);
    chk({nm, "_busy_cycles"}, busy_cnt, exp_busy);
    chk({nm, "_strb_cycles"}, strb_cnt, NB * DIV + ((hold_at > 0) ? 10 : 0));
    $display("word %s: beats=%0d busy_cycles=%0d strobe_cycles=%0d", nm, n, busy_cnt, strb_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and push with the serializer disabled
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_oeb", pad_oeb, 9'h1FF);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    tick(); rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    push_word(32'h12345678);
    @(negedge clk);
    chk("s1_level", level, 1);
    chk("s1_oeb", pad_oeb, 9'h1FF);
    chk("s1_strb", pad_strb, 0);

    // Single word playback
    tick(); en = 1'b1;
`ifdef PSEUDO_SER_FRAME_EN
    run_word("s2", 5, 8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 40, 0, 0);
`else
    run_word("s2", 4, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 32, 0, 0);
`endif
    chk("s2_level", level, 0);
    tick(); en = 1'b0;

    // Fill the FIFO, then a push attempt during the first pop is refused
    tick(); in_valid = 1'b1; in_data = 32'h01020304;
    tick(); in_data = 32'hA0B0C0D0;
    tick(); in_data = 32'hFFFFFFFF;
    tick(); in_data = 32'h00000000;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("s3_full_ready", in_ready, 0);
    chk("s3_full_level", level, 4);
    tick(); en = 1'b1; in_valid = 1'b1; in_data = 32'h5A5A5A5A;
    tick(); in_valid = 1'b0;
    @(negedge clk);
    chk("s3_level_after_pop", level, 3);
    chk("s3_ready_after_pop", in_ready, 1);
    wait_idle(4 * T + 50);
    chk("s3_drained", level, 0);
    tick(); en = 1'b0;

    // Hold for 10 cycles during the second strobe
    push_word(32'h12345678);
    tick(); en = 1'b1;
`ifdef PSEUDO_SER_FRAME_EN
    run_word("s4", 5, 8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 50, 2, 0);
`else
    run_word("s4", 4, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 42, 2, 0);
`endif
    tick(); en = 1'b0;

    // Drop enable during the first strobe with a second word queued
    push_word(32'hCAFEF00D);
    push_word(32'h0BADBEEF);
    tick(); en = 1'b1;
`ifdef PSEUDO_SER_FRAME_EN
    run_word("s5", 5, 8'hA5, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 40, 0, 1);
`else
    run_word("s5", 4, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h00, 32, 0, 1);
`endif
    chk("s5_level", level, 1);
    chk("s5_oeb", pad_oeb, 9'h1FF);

    // Reset in the middle of a word
    tick(); en = 1'b1;
    repeat (12) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", pad_data, 0);
    chk("midrst_oeb", pad_oeb, 9'h1FF);
    tick(); rst_n = 1'b1; en = 1'b0;
    tick();

    // Final word
    push_word(32'hDEADBEEF);
    tick(); en = 1'b1;
`ifdef PSEUDO_SER_FRAME_EN
    run_word("s6", 5, 8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 40, 0, 0);
`else
    run_word("s6", 4, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 32, 0, 0);
`endif
    tick(); en = 1'b0;
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
